// File: rtl/mem_port_arbiter.sv
// Shares one physical memory port between the instruction-fetch and load/store
// requesters; the winning request is latched, driven to memory, and answered with a one-cycle resp.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_enable,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_byte_enable,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, state_next;
  logic [3:0]  starve_cnt;
  logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0]  be_q;
  logic        write_q, owner_d;
  logic        d_req, grant_i, grant_d;

  // Fetch wins only when it is alone or data has already won LIMIT contended rounds.
  always_comb begin
    d_req   = d_read | d_write;
    grant_i = (state == IDLE) && i_read && (!d_req || (starve_cnt == LIMIT));
    grant_d = (state == IDLE) && d_req && !grant_i;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_next = RESP;
      end
      SERVE_D: begin
        pmem_read  = !write_q;
        pmem_write = write_q;
        if (pmem_resp) state_next = RESP;
      end
      RESP: begin
        i_resp     = !owner_d;
        d_resp     = owner_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A write with a simultaneous read is treated as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      write_q    <= 1'b0;
      owner_d    <= 1'b0;
      i_rdata_q  <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      if (grant_i) begin
        addr_q     <= i_address;
        wdata_q    <= 32'd0;
        be_q       <= 4'hF;
        write_q    <= 1'b0;
        owner_d    <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        be_q    <= d_byte_enable;
        write_q <= d_write;
        owner_d <= 1'b1;
        if (i_read && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 4'd1;
      end
      if ((state == SERVE_I) && pmem_resp) i_rdata_q <= pmem_rdata;
      if ((state == SERVE_D) && pmem_resp && !write_q) d_rdata_q <= pmem_rdata;
    end
  end

  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_byte_enable = be_q;
  assign i_rdata          = i_rdata_q;
  assign d_rdata          = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for starvation and
// mid-transaction reset, then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 2;

  logic        clk, rst;
  logic        i_read, d_read, d_write, pmem_resp;
  logic [31:0] i_address, d_address, d_wdata, pmem_rdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
  logic        i_resp, d_resp, pmem_read, pmem_write;
  logic [3:0]  pmem_byte_enable;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rst, ir;  logic [31:0] ia;
    logic dr, dw;   logic [31:0] da, dwd; logic [3:0] dbe;
    logic pr;       logic [31:0] prd;
    logic er, ew, ck; logic [31:0] ea, ewd; logic [3:0] ebe;
    logic eir;      logic [31:0] eird;
    logic edr;      logic [31:0] edrd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dwd, input logic [3:0] dbe,
                     input logic pr, input logic [31:0] prd,
                     input logic er, input logic ew, input logic ck,
                     input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ebe,
                     input logic eir, input logic [31:0] eird,
                     input logic edr, input logic [31:0] edrd);
    vec_t v;
    v.rst = r;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.dbe = dbe; v.pr = pr; v.prd = prd; v.er = er; v.ew = ew; v.ck = ck; v.ea = ea;
    v.ewd = ewd; v.ebe = ebe; v.eir = eir; v.eird = eird; v.edr = edr; v.edrd = edrd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_wdata = 0; d_byte_enable = 0; pmem_resp = 0; pmem_rdata = 0;
  endtask

  localparam logic [31:0] IW = 32'h00A00093;
  localparam logic [31:0] DW = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;

  int          resp_due, resp_next, tr_owner, starve_m, w, op, gcount;
  int          g[6];
  int          exp_g[6];
  logic        strobe, prev_strobe, tr_write, d_any;
  logic        i_busy, i_gr, d_busy, d_gr;
  logic [31:0] tr_addr, tr_wdata, exp_i, exp_d;
  logic [3:0]  tr_be;

  initial begin
    rst = 1;
    idle_inputs();

    // reset, lone fetch, lone store with waits and address change, idle pmem_resp, read, illegal op
    add(1, 0,0,     0,0,0,0,0,        0,0,        0,0,1,0,0,0,           0,0,  0,0);
    add(0, 1,'h60,  0,0,0,0,0,        0,0,        1,0,1,'h60,0,'hF,      0,0,  0,0);
    add(0, 1,'h60,  0,0,0,0,0,        1,IW,       0,0,0,0,0,0,           1,IW, 0,0);
    add(0, 0,0,     0,0,0,0,0,        0,0,        0,0,0,0,0,0,           0,IW, 0,0);
    add(0, 0,0,     0,1,'h100,DW,'h3, 0,0,        0,1,1,'h100,DW,'h3,    0,IW, 0,0);
    add(0, 0,0,     0,1,'h999,DW,'h3, 0,0,        0,1,1,'h100,DW,'h3,    0,IW, 0,0);
    add(0, 0,0,     0,1,'h999,DW,'h3, 0,0,        0,1,1,'h100,DW,'h3,    0,IW, 0,0);
    add(0, 0,0,     0,1,'h100,DW,'h3, 0,0,        0,1,1,'h100,DW,'h3,    0,IW, 0,0);
    add(0, 0,0,     0,1,'h100,DW,'h3, 1,'h5555,   0,0,0,0,0,0,           0,IW, 1,0);
    add(0, 0,0,     0,0,0,0,0,        0,0,        0,0,0,0,0,0,           0,IW, 0,0);
    add(0, 0,0,     0,0,0,0,0,        1,'hBAD,    0,0,0,0,0,0,           0,IW, 0,0);
    add(0, 0,0,     1,0,'h300,0,'hF,  0,0,        1,0,1,'h300,0,'hF,     0,IW, 0,0);
    add(0, 0,0,     1,0,'h300,0,'hF,  1,CF,       0,0,0,0,0,0,           0,IW, 1,CF);
    add(0, 0,0,     0,0,0,0,0,        0,0,        0,0,0,0,0,0,           0,IW, 0,CF);
    add(0, 0,0,     1,1,'h200,'h1234,'hF, 0,0,    0,1,1,'h200,'h1234,'hF,0,IW, 0,CF);
    add(0, 0,0,     1,1,'h200,'h1234,'hF, 1,'hFFFFFFFF, 0,0,0,0,0,0,     0,IW, 1,CF);
    add(0, 0,0,     0,0,0,0,0,        0,0,        0,0,0,0,0,0,           0,IW, 0,CF);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; i_read = vecs[k].ir; i_address = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_address = vecs[k].da;
      d_wdata = vecs[k].dwd; d_byte_enable = vecs[k].dbe;
      pmem_resp = vecs[k].pr; pmem_rdata = vecs[k].prd;
      step();
      chk($sformatf("vec%0d_pread", k),  32'(pmem_read),  32'(vecs[k].er));
      chk($sformatf("vec%0d_pwrite", k), 32'(pmem_write), 32'(vecs[k].ew));
      chk($sformatf("vec%0d_iresp", k),  32'(i_resp),     32'(vecs[k].eir));
      chk($sformatf("vec%0d_dresp", k),  32'(d_resp),     32'(vecs[k].edr));
      chk($sformatf("vec%0d_irdata", k), i_rdata,         vecs[k].eird);
      chk($sformatf("vec%0d_drdata", k), d_rdata,         vecs[k].edrd);
      if (vecs[k].ck) begin
        chk($sformatf("vec%0d_paddr", k),  pmem_address,            vecs[k].ea);
        chk($sformatf("vec%0d_pwdata", k), pmem_wdata,              vecs[k].ewd);
        chk($sformatf("vec%0d_pbe", k),    32'(pmem_byte_enable),   32'(vecs[k].ebe));
      end
    end

    // contention with both requesters held: expect D, D, I, D, D, I
    rst = 1; idle_inputs(); step(); rst = 0;
    i_read = 1; i_address = 32'h1000; d_read = 1; d_address = 32'h2000;
    exp_g = '{2, 2, 1, 2, 2, 1};
    gcount = 0; prev_strobe = 0;
    for (int c = 0; c < 60 && gcount < 6; c++) begin
      step();
      strobe = pmem_read | pmem_write;
      if (strobe && !prev_strobe) begin
        g[gcount] = (pmem_address == 32'h1000) ? 1 : 2;
        gcount++;
      end
      pmem_resp = strobe;
      prev_strobe = strobe;
    end
    chk("starve_grant_count", 32'(gcount), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < gcount) chk($sformatf("starve_grant%0d", k), 32'(g[k]), 32'(exp_g[k]));

    // reset while a fetch is in flight
    rst = 1; idle_inputs(); step(); rst = 0;
    i_read = 1; i_address = 32'h44; step();
    chk("rm_pread_before", 32'(pmem_read), 32'd1);
    rst = 1; step(); rst = 0;
    chk("rm_pread",  32'(pmem_read),  32'd0);
    chk("rm_pwrite", 32'(pmem_write), 32'd0);
    chk("rm_paddr",  pmem_address,    32'd0);
    chk("rm_pwdata", pmem_wdata,      32'd0);
    chk("rm_pbe",    32'(pmem_byte_enable), 32'd0);
    chk("rm_iresp",  32'(i_resp),     32'd0);
    chk("rm_dresp",  32'(d_resp),     32'd0);
    chk("rm_irdata", i_rdata,         32'd0);
    chk("rm_drdata", d_rdata,         32'd0);
    i_address = 32'h48; step();
    chk("rm_fresh_pread", 32'(pmem_read), 32'd1);
    chk("rm_fresh_paddr", pmem_address,   32'h48);
    chk("rm_fresh_iresp0", 32'(i_resp),   32'd0);
    pmem_resp = 1; pmem_rdata = 32'h77; step();
    chk("rm_fresh_iresp", 32'(i_resp), 32'd1);
    chk("rm_fresh_irdata", i_rdata,    32'h77);
    i_read = 0; pmem_resp = 0; step();
    chk("rm_fresh_iresp_end", 32'(i_resp), 32'd0);

    // randomized traffic against the transaction-level model
    rst = 1; idle_inputs(); step(); rst = 0;
    exp_i = 0; exp_d = 0; starve_m = 0; resp_due = 0; prev_strobe = 0; tr_owner = 0;
    tr_addr = 0; tr_wdata = 0; tr_be = 0; tr_write = 0;
    i_busy = 0; i_gr = 0; d_busy = 0; d_gr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      strobe = pmem_read | pmem_write;
      chk("r_iresp",  32'(i_resp), 32'(resp_due == 1));
      chk("r_dresp",  32'(d_resp), 32'(resp_due == 2));
      chk("r_irdata", i_rdata, exp_i);
      chk("r_drdata", d_rdata, exp_d);
      if (strobe && !prev_strobe) begin
        d_any = d_read | d_write;
        chk("r_grant_had_req", 32'(i_read | d_any), 32'd1);
        w = (i_read && (!d_any || starve_m == LIMIT)) ? 1 : 2;
        if (w == 1) begin
          tr_addr = i_address; tr_write = 0; tr_wdata = 0; tr_be = 4'hF;
          starve_m = 0; i_gr = 1;
        end else begin
          tr_addr = d_address; tr_write = d_write; tr_wdata = d_wdata; tr_be = d_byte_enable;
          if (i_read && starve_m < LIMIT) starve_m++;
          d_gr = 1;
        end
        tr_owner = w;
      end
      if (strobe) begin
        chk("r_paddr",  pmem_address, tr_addr);
        chk("r_pwdata", pmem_wdata,   tr_wdata);
        chk("r_pbe",    32'(pmem_byte_enable), 32'(tr_be));
        chk("r_pread",  32'(pmem_read),  32'(!tr_write));
        chk("r_pwrite", 32'(pmem_write), 32'(tr_write));
      end

      if (resp_due == 1) begin i_read = 0; i_busy = 0; i_gr = 0; end
      if (resp_due == 2) begin d_read = 0; d_write = 0; d_busy = 0; d_gr = 0; end
      if (!i_busy && ($urandom % 3 == 0)) begin
        i_read = 1; i_address = {4'h1, 28'($urandom)}; i_busy = 1;
      end else if (i_gr && ($urandom % 2 == 0)) begin
        i_address = $urandom;
      end
      if (!d_busy && ($urandom % 3 == 0)) begin
        op = $urandom % 10;
        d_read = (op < 5) || (op == 9); d_write = (op >= 5);
        d_address = {4'h2, 28'($urandom)}; d_wdata = $urandom;
        d_byte_enable = 4'($urandom); d_busy = 1;
      end else if (d_gr && ($urandom % 2 == 0)) begin
        d_address = $urandom; d_wdata = $urandom; d_byte_enable = 4'($urandom);
      end

      resp_next = 0;
      pmem_rdata = $urandom;
      if (strobe) begin
        if ($urandom % 2 == 0) begin
          pmem_resp = 1; resp_next = tr_owner;
          if (tr_owner == 1)  exp_i = pmem_rdata;
          else if (!tr_write) exp_d = pmem_rdata;
        end else begin
          pmem_resp = 0;
        end
      end else begin
        pmem_resp = ($urandom % 4 == 0);
      end
      resp_due = resp_next;
      prev_strobe = strobe;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single physical memory port between the instruction-fetch path and the load/store path of the rv32i core. It is required once fetch and data access are split into independent requesters, such as split I/D caches or an overlapped fetch. Each requester sees the same read/write/resp handshake the control FSM already uses. The arbiter registers the winning request, drives it to physical memory, and returns a one-cycle registered response to the owner.

## Interface
- STARVE_LIMIT, default 4: maximum consecutive contended data grants before instruction fetch is forced to win; legal range 1..15.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  instruction read request; held until i_resp.
- i_address  in  32  instruction address.
- i_rdata  out  32  instruction read data; valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse for the instruction requester.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_address  in  32  data address.
- d_wdata  in  32  store data.
- d_byte_enable  in  4  store byte mask (rv32i_mem_wmask).
- d_rdata  out  32  data read data; valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse for the data requester.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  32  physical address.
- pmem_wdata  out  32  physical write data.
- pmem_byte_enable  out  4  physical byte mask.
- pmem_rdata  in  32  physical read data; valid with pmem_resp.
- pmem_resp  in  1  physical completion; may arrive any cycle ≥ first strobe cycle.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP.
- **IDLE:** all strobes 0. Requests are sampled here.
  - Only I requests: register i_address, go to SERVE_I.
  - Only D requests (d_read or d_write): register address, wdata, byte_enable and op, go to SERVE_D.
  - Both request: if starve_cnt == STARVE_LIMIT, grant I; otherwise grant D.
  - No request: stay in IDLE.
- **Data op conflict:** d_read and d_write both 1 is illegal. Write takes precedence and the read is ignored.
- **starve_cnt** (4 bits):
  - Increments, saturating at STARVE_LIMIT, on each D grant made while i_read=1.
  - Cleared on every I grant.
  - Unchanged on a D grant with i_read=0.
- **SERVE_I:**
  - pmem_read=1, pmem_write=0.
  - pmem_address = latched address, pmem_byte_enable=4'b1111, pmem_wdata=0.
  - On pmem_resp: latch pmem_rdata into i_rdata register, go to RESP with owner=I.
- **SERVE_D:**
  - pmem_read or pmem_write per latched op; address, wdata and byte_enable come from the latches.
  - On pmem_resp: for reads, latch pmem_rdata into the d_rdata register; for writes, d_rdata is unchanged. Go to RESP with owner=D.
- **RESP:**
  - Pulse owner's resp for exactly one cycle; the other resp stays 0. Strobes are 0.
  - Next state is always IDLE, so a requester dropping its request after its resp is never re-granted.
- pmem outputs come only from latches, so requester input changes after grant do not affect an in-flight access.
- A requester that drops its request mid-SERVE still gets its access completed and its resp pulsed.
- i_rdata and d_rdata are separate registers and hold their value until the next matching read completes.

## Timing
- **Reset values:** state=IDLE, starve_cnt=0, all strobes 0, i_resp=d_resp=0. i_rdata, d_rdata, pmem_address, pmem_wdata and pmem_byte_enable are all 0.
- **Reset mid-transaction:** next cycle is IDLE with strobes 0. No resp pulse is issued and the latched request is discarded.
- **Latency:**
  - Request first seen in IDLE at cycle N; strobe asserted N+1.
  - If pmem_resp arrives at cycle M ≥ N+1, owner's resp is pulsed at M+1; IDLE at M+2.
  - Minimum request-to-resp latency is 2 cycles.
- **Turnaround:** back-to-back transactions are separated by at least one IDLE cycle. The minimum period is 3 cycles per access with zero-wait memory.
- pmem_resp while in IDLE or RESP is ignored.

## Test plan
- **Lone fetch:** i_read=1, i_address=0x60, pmem_resp at the first strobe cycle with rdata=0x00A00093. Expect pmem_read in cycle 1 only, i_resp=1 with i_rdata=0x00A00093 in cycle 2, and d_resp=0 throughout.
- **Lone store with wait states:** d_write=1, addr=0x100, wdata=0xDEADBEEF, be=4'b0011, pmem_resp after 3 wait cycles. Expect strobe held 4 cycles with latched values, one d_resp pulse, and d_rdata unchanged.
- **Contention/starvation, STARVE_LIMIT=2:** i_read and d_read both held continuously; D re-requests right after each d_resp. Expect grant order D, D, I, D, D, I, with starve_cnt 1, 2, 0 at each grant.
- **Input change after grant:** during SERVE_D change d_address to 0x999. Expect pmem_address to stay at the originally latched value.
- **Reset mid-SERVE_I:** assert rst one cycle while pmem_read=1. Expect next cycle all outputs 0, no i_resp, starve_cnt=0, and a fresh request served normally.
- **Illegal op:** d_read=d_write=1. Expect pmem_write=1, pmem_read=0, and d_rdata unchanged after d_resp.
